// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared types and defaults for tick_scheduler
package tick_sched_pkg;

  typedef enum logic {IDLE, PENDING} state_t;

  localparam int DEF_PRESCALE  = 100;
  localparam int DEF_DIV_WIDTH = 16;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one divide-by-D channel of the tick scheduler
// Optional square output under TICK_SCHED_SQUARE_EN.
module tick_channel #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_base_tick,
  input  logic                 i_apply,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_en,
`ifdef TICK_SCHED_SQUARE_EN
  output logic                 o_sq,
`endif
  output logic                 o_tick,
  output logic                 o_active
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_en;
  logic                 r_tick;
  logic                 w_fire;

  // An apply in the same cycle wins over counting, so no pulse lands on the apply edge.
  assign w_fire = r_en && i_base_tick && !i_apply &&
                  (r_cnt == (r_div - DIV_WIDTH'(1)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_div  <= '0;
      r_en   <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_apply) begin
      r_div  <= i_div;
      r_cnt  <= '0;
      r_en   <= i_en && (i_div != '0);
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_fire;
      if (r_en && i_base_tick)
        r_cnt <= w_fire ? '0 : r_cnt + DIV_WIDTH'(1);
    end
  end

`ifdef TICK_SCHED_SQUARE_EN
  logic r_sq;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_sq <= 1'b0;
    else if (i_apply && !(i_en && (i_div != '0)))
      r_sq <= 1'b0;
    else if (!r_en)
      r_sq <= 1'b0;
    else if (w_fire)
      r_sq <= ~r_sq;
  end

  assign o_sq = r_sq;
`endif

  assign o_tick   = r_tick;
  assign o_active = r_en;

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - shared prescaler, config FSM and N_CH tick channels
// TICK_SCHED_SQUARE_EN adds the sq_out square-wave outputs.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int PRESCALE  = DEF_PRESCALE,
  parameter  int DIV_WIDTH = DEF_DIV_WIDTH,
  localparam int CH_W      = ch_width(N_CH)
) (
  input  logic                 In_clok,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_en,
  output logic [N_CH-1:0]      tick_out,
`ifdef TICK_SCHED_SQUARE_EN
  output logic [N_CH-1:0]      sq_out,
`endif
  output logic [N_CH-1:0]      active
);

  localparam int P_W = $clog2(PRESCALE);

  logic [P_W-1:0]       r_p;
  logic                 w_base_tick;
  state_t               r_state;
  state_t               w_next;
  logic                 w_accept;
  logic                 w_apply;
  logic [CH_W-1:0]      r_pend_ch;
  logic [DIV_WIDTH-1:0] r_pend_div;
  logic                 r_pend_en;

  assign w_base_tick = (r_p == P_W'(PRESCALE - 1));

  always_ff @(posedge In_clok) begin
    if (reset || w_base_tick)
      r_p <= '0;
    else
      r_p <= r_p + P_W'(1);
  end

  always_comb begin
    w_next    = r_state;
    cfg_ready = 1'b0;
    w_accept  = 1'b0;
    w_apply   = 1'b0;
    case (r_state)
      IDLE: begin
        cfg_ready = !reset;
        w_accept  = cfg_valid && !reset;
        if (w_accept)
          w_next = PENDING;
      end
      PENDING: begin
        w_apply = w_base_tick;
        if (w_base_tick)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge In_clok) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pend_ch  <= '0;
      r_pend_div <= '0;
      r_pend_en  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pend_ch  <= cfg_ch;
        r_pend_div <= cfg_div;
        r_pend_en  <= cfg_en;
      end
    end
  end

  // Out-of-range channel selects match no instance, so they apply as a no-op.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    tick_channel #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_ch (
      .i_clk       (In_clok),
      .i_reset     (reset),
      .i_base_tick (w_base_tick),
      .i_apply     (w_apply && (r_pend_ch == CH_W'(gi))),
      .i_div       (r_pend_div),
      .i_en        (r_pend_en),
`ifdef TICK_SCHED_SQUARE_EN
      .o_sq        (sq_out[gi]),
`endif
      .o_tick      (tick_out[gi]),
      .o_active    (active[gi])
    );
  end

endmodule
